scaler_read_seq: RTL and testbench

Read sequencer and arbiter for the scaler channel-read interface. It serves two requesters: CPU channel logic (port 0) and downlink/telemetry (port 1). For each request it returns one coherent 28-bit scaler snapshot, built from the high half (channel CHAT) and the low half (channel CHBT), by driving the scaler's active-low read strobes RCHAT_/RCHBT_. It sits between the scaler module and its consumers and is the only driver of RCHAT_/RCHBT_.

---
 rtl/scaler_read_seq.sv | 180 ++++++++++++++++++
 tb/tb_scaler_read_seq.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scaler_read_seq.sv
// Read sequencer/arbiter for the scaler channel-read interface: two requesters share
// one high/low strobe sequence that returns a coherent {high, low} snapshot.
module scaler_read_seq #(
    parameter int HW        = 14,
    parameter int MAX_RETRY = 1
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic            REQ0,
    input  logic            REQ1,
    input  logic [HW-1:0]   CHAT,
    input  logic [HW-1:0]   CHBT,
    output logic            RCHAT_,
    output logic            RCHBT_,
    output logic            ACK0,
    output logic            ACK1,
    output logic [2*HW-1:0] DOUT,
    output logic            ERR
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RDH1 = 3'd1,
        S_RDL  = 3'd2,
        S_RDH2 = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_gnt;
    logic            r_last;
    logic            w_gnt_sel;
    logic [RW-1:0]   r_retry;
    logic [HW-1:0]   r_hi;
    logic [HW-1:0]   r_lo;
    logic            w_match;
    logic            w_retry_ok;
    logic            r_rchat_n;
    logic            r_rchbt_n;
    logic            r_ack0;
    logic            r_ack1;
    logic            r_err;
    logic [2*HW-1:0] r_dout;
    logic            w_rchat_n;
    logic            w_rchbt_n;
    logic            w_ack0;
    logic            w_ack1;

    assign w_match    = (CHAT == r_hi);
    assign w_retry_ok = (r_retry < RW'(MAX_RETRY));

    assign RCHAT_ = r_rchat_n;
    assign RCHBT_ = r_rchbt_n;
    assign ACK0   = r_ack0;
    assign ACK1   = r_ack1;
    assign DOUT   = r_dout;
    assign ERR    = r_err;

    // Arbitration: on contention the port not served last wins.
    always_comb begin
        if (REQ0 && REQ1) begin
            w_gnt_sel = ~r_last;
        end else if (REQ1) begin
            w_gnt_sel = 1'b1;
        end else begin
            w_gnt_sel = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a high-half mismatch re-reads low and high while retries remain.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (REQ0 || REQ1) begin
                    w_next = S_RDH1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_RDH1: w_next = S_RDL;
            S_RDL:  w_next = S_RDH2;
            S_RDH2: begin
                if (!w_match && w_retry_ok) begin
                    w_next = S_RDL;
                end else begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode from the next state so strobes and ACK come straight from flops.
    always_comb begin
        w_rchat_n = 1'b1;
        w_rchbt_n = 1'b1;
        w_ack0    = 1'b0;
        w_ack1    = 1'b0;
        case (w_next)
            S_RDH1, S_RDH2: w_rchat_n = 1'b0;
            S_RDL:          w_rchbt_n = 1'b0;
            S_DONE: begin
                w_ack0 = ~r_gnt;
                w_ack1 = r_gnt;
            end
            default: begin
                w_rchat_n = 1'b1;
                w_rchbt_n = 1'b1;
            end
        endcase
    end

    // Registered strobes and ACK pulses.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_rchat_n <= 1'b1;
            r_rchbt_n <= 1'b1;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
        end else begin
            r_rchat_n <= w_rchat_n;
            r_rchbt_n <= w_rchbt_n;
            r_ack0    <= w_ack0;
            r_ack1    <= w_ack1;
        end
    end

    // Snapshot datapath, grant/fairness bookkeeping and result registers.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
            r_retry <= {RW{1'b0}};
            r_hi    <= {HW{1'b0}};
            r_lo    <= {HW{1'b0}};
            r_dout  <= {(2*HW){1'b0}};
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (REQ0 || REQ1) begin
                        r_gnt   <= w_gnt_sel;
                        r_retry <= {RW{1'b0}};
                    end
                end
                S_RDH1: r_hi <= CHAT;
                S_RDL:  r_lo <= CHBT;
                S_RDH2: begin
                    if (w_match) begin
                        r_dout <= {r_hi, r_lo};
                        r_err  <= 1'b0;
                    end else if (w_retry_ok) begin
                        r_hi    <= CHAT;
                        r_retry <= r_retry + RW'(1);
                    end else begin
                        r_dout <= {CHAT, r_lo};
                        r_err  <= 1'b1;
                    end
                end
                S_DONE:  r_last <= r_gnt;
                default: r_last <= r_last;
            endcase
        end
    end

endmodule

// File: tb/tb_scaler_read_seq.sv
// Self-checking bench for scaler_read_seq: scoreboard queues of expected ACKs
// against a behavioural scaler stub (stable, single carry, or free-running high half).
module tb_scaler_read_seq;

    typedef struct {
        logic        port;
        logic        err;
        logic [27:0] dout;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_;
    logic        REQ0;
    logic        REQ1;
    logic [13:0] CHAT;
    logic [13:0] CHBT;
    logic        RCHAT_;
    logic        RCHBT_;
    logic        ACK0;
    logic        ACK1;
    logic [27:0] DOUT;
    logic        ERR;

    int          checks;
    int          errors;
    exp_t        sb[$];
    exp_t        sb0[$];
    exp_t        sb1[$];

    logic [1:0]  mode;
    logic [13:0] bh;
    logic [13:0] bl;
    int          cyc;
    int          cyc_mark;
    int          nlo;
    int          nlo_mark;

    scaler_read_seq #(.HW(14), .MAX_RETRY(1)) dut (
        .clk   (clk),
        .rst_  (rst_),
        .REQ0  (REQ0),
        .REQ1  (REQ1),
        .CHAT  (CHAT),
        .CHBT  (CHBT),
        .RCHAT_(RCHAT_),
        .RCHBT_(RCHBT_),
        .ACK0  (ACK0),
        .ACK1  (ACK1),
        .DOUT  (DOUT),
        .ERR   (ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!RCHBT_) nlo <= nlo + 1;
    end

    // Scaler stub: mode 1 carries {hi,lo} by one after the first low read,
    // mode 2 advances the high half every cycle.
    always_comb begin
        case (mode)
            2'd1: {CHAT, CHBT} = {bh, bl} + ((nlo != nlo_mark) ? 28'd1 : 28'd0);
            2'd2: begin
                CHAT = bh + 14'(cyc - cyc_mark);
                CHBT = bl;
            end
            default: begin
                CHAT = bh;
                CHBT = bl;
            end
        endcase
    end

    task automatic apply_reset();
        rst_ = 1'b0;
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({RCHAT_, RCHBT_, ACK0, ACK1, ERR, DOUT} !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 28'd0}) begin
            errors++;
            $display("FAIL reset_values got %b %b %b %b %b %h required 1 1 0 0 0 0000000",
                     RCHAT_, RCHBT_, ACK0, ACK1, ERR, DOUT);
        end
        rst_ = 1'b1;
    endtask

    task automatic test_single();
        exp_t e;
        mode = 2'd0;
        bh = 14'h0155;
        bl = 14'h2AAA;
        @(negedge clk);
        REQ0 = 1'b1;
        sb.push_back('{port: 1'b0, err: 1'b0, dout: 28'h0556AAA, cyc: 4});
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            REQ0 = 1'b0;
            checks++;
            if ({RCHAT_, RCHBT_} !== {!(k == 1 || k == 3), (k != 2)}) begin
                errors++;
                $display("FAIL single_strobes cycle %0d got %b%b required %b%b", k, RCHAT_, RCHBT_,
                         !(k == 1 || k == 3), (k != 2));
            end
            if (ACK0 || ACK1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL single_extra_ack cycle %0d ACK0=%b ACK1=%b required none", k, ACK0, ACK1);
                end else begin
                    e = sb.pop_front();
                    if ({ACK1, ACK0, ERR, DOUT, k} !== {e.port, ~e.port, e.err, e.dout, e.cyc}) begin
                        errors++;
                        $display("FAIL single_ack got ack=%b%b err=%b dout=%h cyc=%0d required port=%b err=%b dout=%h cyc=%0d",
                                 ACK1, ACK0, ERR, DOUT, k, e.port, e.err, e.dout, e.cyc);
                    end
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL single_timeout pending %0d required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_carry();
        exp_t e;
        mode = 2'd1;
        bh = 14'h0155;
        bl = 14'h3FFF;
        @(negedge clk);
        nlo_mark = nlo;
        REQ0 = 1'b1;
        sb.push_back('{port: 1'b0, err: 1'b0, dout: {14'h0156, 14'h0000}, cyc: 6});
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            REQ0 = 1'b0;
            if (ACK0 || ACK1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL carry_extra_ack cycle %0d required none", k);
                end else begin
                    e = sb.pop_front();
                    if ({ACK1, ACK0, ERR, DOUT, k} !== {e.port, ~e.port, e.err, e.dout, e.cyc}) begin
                        errors++;
                        $display("FAIL carry_ack got ack=%b%b err=%b dout=%h cyc=%0d required port=%b err=%b dout=%h cyc=%0d",
                                 ACK1, ACK0, ERR, DOUT, k, e.port, e.err, e.dout, e.cyc);
                    end
                end
            end
        end
        checks++;
        if ((nlo - nlo_mark) != 2 || sb.size() != 0) begin
            errors++;
            $display("FAIL carry_retry low_reads=%0d pending=%0d required 2 and 0", nlo - nlo_mark, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_persistent();
        exp_t e;
        mode = 2'd2;
        bh = 14'h0100;
        bl = 14'h0123;
        @(negedge clk);
        cyc_mark = cyc;
        nlo_mark = nlo;
        REQ1 = 1'b1;
        sb.push_back('{port: 1'b1, err: 1'b1, dout: {14'h0105, 14'h0123}, cyc: 6});
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            REQ1 = 1'b0;
            if (ACK0 || ACK1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL persist_extra_ack cycle %0d required none", k);
                end else begin
                    e = sb.pop_front();
                    if ({ACK1, ACK0, ERR, DOUT, k} !== {e.port, ~e.port, e.err, e.dout, e.cyc}) begin
                        errors++;
                        $display("FAIL persist_ack got ack=%b%b err=%b dout=%h cyc=%0d required port=%b err=%b dout=%h cyc=%0d",
                                 ACK1, ACK0, ERR, DOUT, k, e.port, e.err, e.dout, e.cyc);
                    end
                end
            end
        end
        checks++;
        if ((nlo - nlo_mark) != 2 || sb.size() != 0) begin
            errors++;
            $display("FAIL persist_low_reads got %0d pending=%0d required 2 and 0", nlo - nlo_mark, sb.size());
            sb.delete();
        end
        mode = 2'd0;
    endtask

    task automatic test_contention();
        exp_t e;
        apply_reset();
        mode = 2'd0;
        bh = 14'h1234;
        bl = 14'h0ABC;
        @(negedge clk);
        REQ0 = 1'b1;
        REQ1 = 1'b1;
        sb.push_back('{port: 1'b0, err: 1'b0, dout: {bh, bl}, cyc: 4});
        sb.push_back('{port: 1'b1, err: 1'b0, dout: {bh, bl}, cyc: 9});
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (ACK0 || ACK1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL contend_extra_ack cycle %0d required none", k);
                end else begin
                    e = sb.pop_front();
                    if ({ACK1, ACK0, DOUT, k} !== {e.port, ~e.port, e.dout, e.cyc}) begin
                        errors++;
                        $display("FAIL contend_ack got ack=%b%b dout=%h cyc=%0d required port=%b dout=%h cyc=%0d",
                                 ACK1, ACK0, DOUT, k, e.port, e.dout, e.cyc);
                    end
                end
                if (ACK1) begin
                    REQ0 = 1'b0;
                    REQ1 = 1'b0;
                end
            end
        end
        repeat (3) @(negedge clk);
        REQ0 = 1'b1;
        REQ1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sb.push_back('{port: i[0], err: 1'b0, dout: {bh, bl}, cyc: 4 + 5 * i});
        end
        for (int k = 1; k <= 56; k++) begin
            @(negedge clk);
            if (ACK0 || ACK1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL alternate_extra_ack cycle %0d required none", k);
                end else begin
                    e = sb.pop_front();
                    if ({ACK1, ACK0, DOUT, k} !== {e.port, ~e.port, e.dout, e.cyc}) begin
                        errors++;
                        $display("FAIL alternate_ack got ack=%b%b dout=%h cyc=%0d required port=%b dout=%h cyc=%0d",
                                 ACK1, ACK0, DOUT, k, e.port, e.dout, e.cyc);
                    end
                end
                if (sb.size() == 0) begin
                    REQ0 = 1'b0;
                    REQ1 = 1'b0;
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL alternate_timeout pending %0d required 0", sb.size());
            sb.delete();
        end
        REQ0 = 1'b0;
        REQ1 = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        mode = 2'd0;
        bh = 14'h2468;
        bl = 14'h1357;
        @(negedge clk);
        REQ0 = 1'b1;
        @(negedge clk);
        REQ0 = 1'b0;
        @(negedge clk);
        checks++;
        if (RCHBT_ !== 1'b0) begin
            errors++;
            $display("FAIL midreset_in_rdl got RCHBT_=%b required 0", RCHBT_);
        end
        rst_ = 1'b0;
        #1;
        checks++;
        if ({RCHAT_, RCHBT_, ACK0, ACK1, ERR, DOUT} !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 28'd0}) begin
            errors++;
            $display("FAIL midreset_values got %b %b %b %b %b %h required 1 1 0 0 0 0000000",
                     RCHAT_, RCHBT_, ACK0, ACK1, ERR, DOUT);
        end
        @(negedge clk);
        rst_ = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (ACK0 || ACK1 || !RCHAT_ || !RCHBT_) begin
                errors++;
                $display("FAIL midreset_quiet got ack=%b%b strobes=%b%b required 00 11", ACK1, ACK0, RCHAT_, RCHBT_);
            end
        end
        REQ1 = 1'b1;
        sb.push_back('{port: 1'b1, err: 1'b0, dout: {bh, bl}, cyc: 4});
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (ACK0 || ACK1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL midreset_extra_ack cycle %0d required none", k);
                end else begin
                    e = sb.pop_front();
                    if ({ACK1, ACK0, ERR, DOUT, k} !== {e.port, ~e.port, e.err, e.dout, e.cyc}) begin
                        errors++;
                        $display("FAIL midreset_ack got ack=%b%b err=%b dout=%h cyc=%0d required port=%b err=%b dout=%h cyc=%0d",
                                 ACK1, ACK0, ERR, DOUT, k, e.port, e.err, e.dout, e.cyc);
                    end
                end
                REQ1 = 1'b0;
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL midreset_timeout pending %0d required 0", sb.size());
            sb.delete();
        end
        REQ1 = 1'b0;
    endtask

    task automatic test_random();
        exp_t e;
        mode = 2'd0;
        bh = 14'($urandom);
        bl = 14'($urandom);
        for (int n = 0; n < 10030; n++) begin
            @(negedge clk);
            checks++;
            if (!RCHAT_ && !RCHBT_) begin
                errors++;
                $display("FAIL rand_strobes both low at step %0d required at most one", n);
            end
            if (ACK0 && ACK1) begin
                errors++;
                $display("FAIL rand_dual_ack at step %0d required single ACK", n);
            end
            if (ACK0) begin
                checks++;
                if (sb0.size() == 0) begin
                    errors++;
                    $display("FAIL rand_ack0_ungranted at step %0d required no ACK0", n);
                end else begin
                    e = sb0.pop_front();
                    if ({ERR, DOUT} !== {e.err, e.dout}) begin
                        errors++;
                        $display("FAIL rand_ack0_data got err=%b dout=%h required err=%b dout=%h", ERR, DOUT, e.err, e.dout);
                    end
                end
                REQ0 = 1'b0;
            end
            if (ACK1) begin
                checks++;
                if (sb1.size() == 0) begin
                    errors++;
                    $display("FAIL rand_ack1_ungranted at step %0d required no ACK1", n);
                end else begin
                    e = sb1.pop_front();
                    if ({ERR, DOUT} !== {e.err, e.dout}) begin
                        errors++;
                        $display("FAIL rand_ack1_data got err=%b dout=%h required err=%b dout=%h", ERR, DOUT, e.err, e.dout);
                    end
                end
                REQ1 = 1'b0;
            end
            if (n < 10000) begin
                if (!REQ0 && $urandom_range(0, 3) == 0) begin
                    REQ0 = 1'b1;
                    sb0.push_back('{port: 1'b0, err: 1'b0, dout: {bh, bl}, cyc: 0});
                end
                if (!REQ1 && $urandom_range(0, 3) == 0) begin
                    REQ1 = 1'b1;
                    sb1.push_back('{port: 1'b1, err: 1'b0, dout: {bh, bl}, cyc: 0});
                end
            end
        end
        checks++;
        if (sb0.size() != 0 || sb1.size() != 0) begin
            errors++;
            $display("FAIL rand_unserved pending0=%0d pending1=%0d required 0 0", sb0.size(), sb1.size());
        end
        REQ0 = 1'b0;
        REQ1 = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        mode     = 2'd0;
        bh       = 14'd0;
        bl       = 14'd0;
        cyc      = 0;
        cyc_mark = 0;
        nlo      = 0;
        nlo_mark = 0;
        rst_     = 1'b0;
        REQ0     = 1'b0;
        REQ1     = 1'b0;
        test_reset();
        test_single();
        test_carry();
        test_persistent();
        test_contention();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
